wm_cycle_sequencer: RTL



---
 rtl/wm_pkg.sv | 23 ++
 rtl/wm_phase_duration.sv | 27 ++
 rtl/wm_cycle_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/wm_pkg.sv
// Shared types and constants for the washing machine programme sequencer.
// The optional DRY phase is enabled by defining WM_DRY_PHASE_EN.
package wm_pkg;

    localparam int unsigned TIMER_W = 32;
    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4,
        PH_DRY   = 3'd5
    } phase_t;

    localparam logic [TIMER_W-1:0] DEF_FILL_TIME  = 32'd2;
    localparam logic [TIMER_W-1:0] DEF_WASH_TIME  = 32'd5;
    localparam logic [TIMER_W-1:0] DEF_RINSE_TIME = 32'd2;
    localparam logic [TIMER_W-1:0] DEF_SPIN_TIME  = 32'd1;
    localparam logic [TIMER_W-1:0] DEF_DRY_TIME   = 32'd3;

endpackage

// File: rtl/wm_phase_duration.sv
// Combinational lookup from a wash phase to its timer duration in base units.
module wm_phase_duration
    import wm_pkg::*;
#(
    parameter logic [TIMER_W-1:0] FILL_TIME  = DEF_FILL_TIME,
    parameter logic [TIMER_W-1:0] WASH_TIME  = DEF_WASH_TIME,
    parameter logic [TIMER_W-1:0] RINSE_TIME = DEF_RINSE_TIME,
    parameter logic [TIMER_W-1:0] SPIN_TIME  = DEF_SPIN_TIME,
    parameter logic [TIMER_W-1:0] DRY_TIME   = DEF_DRY_TIME
) (
    input  phase_t              phase,
    output logic [TIMER_W-1:0]  duration
);

    always_comb begin
        duration = '0;
        case (phase)
            PH_FILL:  duration = FILL_TIME;
            PH_WASH:  duration = WASH_TIME;
            PH_RINSE: duration = RINSE_TIME;
            PH_SPIN:  duration = SPIN_TIME;
            PH_DRY:   duration = DRY_TIME;
            default:  duration = '0;
        endcase
    end

endmodule

// File: rtl/wm_cycle_sequencer.sv
// Washing machine programme sequencer: walks FILL/WASH/RINSE/SPIN and drives the
// downstream timer. Define WM_DRY_PHASE_EN to insert a DRY phase after SPIN.
module wm_cycle_sequencer
    import wm_pkg::*;
#(
    parameter logic [TIMER_W-1:0] FILL_TIME  = DEF_FILL_TIME,
    parameter logic [TIMER_W-1:0] WASH_TIME  = DEF_WASH_TIME,
    parameter logic [TIMER_W-1:0] RINSE_TIME = DEF_RINSE_TIME,
    parameter logic [TIMER_W-1:0] SPIN_TIME  = DEF_SPIN_TIME,
    parameter logic [TIMER_W-1:0] DRY_TIME   = DEF_DRY_TIME
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_in,
    input  logic                double_wash,
    input  logic                lid_open,
    input  logic                timer_done,
    output logic [TIMER_W-1:0]  timer_value,
    output logic                timer_start,
    output logic                timer_enable,
    output logic [PHASE_W-1:0]  phase,
    output logic                busy,
    output logic                wash_done
);

    phase_t                state_q;
    phase_t                next_phase_c;
    logic                  dw_q;
    logic                  pass_q;
    logic                  done_q_c;
    logic                  pausable_c;
    logic [TIMER_W-1:0]    next_dur_c;

    assign phase = state_q;

    // Stale done from the previous phase is ignored during the start cycle.
    assign done_q_c = timer_done & timer_enable & ~timer_start;

    always_comb begin
        pausable_c = (state_q == PH_SPIN);
`ifdef WM_DRY_PHASE_EN
        pausable_c = pausable_c | (state_q == PH_DRY);
`endif
    end

    // Successor of the current phase; IDLE maps to FILL for the coin start.
    always_comb begin
        next_phase_c = PH_IDLE;
        case (state_q)
            PH_IDLE:  next_phase_c = PH_FILL;
            PH_FILL:  next_phase_c = PH_WASH;
            PH_WASH:  next_phase_c = PH_RINSE;
            PH_RINSE: next_phase_c = (dw_q && !pass_q) ? PH_WASH : PH_SPIN;
`ifdef WM_DRY_PHASE_EN
            PH_SPIN:  next_phase_c = PH_DRY;
`else
            PH_SPIN:  next_phase_c = PH_IDLE;
`endif
            PH_DRY:   next_phase_c = PH_IDLE;
            default:  next_phase_c = PH_IDLE;
        endcase
    end

    wm_phase_duration #(
        .FILL_TIME  (FILL_TIME),
        .WASH_TIME  (WASH_TIME),
        .RINSE_TIME (RINSE_TIME),
        .SPIN_TIME  (SPIN_TIME),
        .DRY_TIME   (DRY_TIME)
    ) u_phase_duration (
        .phase    (next_phase_c),
        .duration (next_dur_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PH_IDLE;
            timer_value  <= '0;
            timer_start  <= 1'b0;
            timer_enable <= 1'b0;
            busy         <= 1'b0;
            wash_done    <= 1'b0;
            dw_q         <= 1'b0;
            pass_q       <= 1'b0;
        end else if (state_q == PH_IDLE) begin
            if (coin_in) begin
                state_q      <= next_phase_c;
                timer_value  <= next_dur_c;
                timer_start  <= 1'b1;
                timer_enable <= 1'b0;
                busy         <= 1'b1;
                wash_done    <= 1'b0;
                dw_q         <= double_wash;
                pass_q       <= 1'b0;
            end
        end else if (timer_start) begin
            timer_start  <= 1'b0;
            timer_enable <= ~(pausable_c & lid_open);
        end else if (done_q_c) begin
            state_q <= next_phase_c;
            if (state_q == PH_RINSE && next_phase_c == PH_WASH) begin
                pass_q <= 1'b1;
            end
            if (next_phase_c == PH_IDLE) begin
                timer_value  <= '0;
                timer_start  <= 1'b0;
                timer_enable <= 1'b0;
                busy         <= 1'b0;
                wash_done    <= 1'b1;
            end else begin
                timer_value  <= next_dur_c;
                timer_start  <= 1'b1;
                timer_enable <= 1'b0;
            end
        end else begin
            // Lid only gates the timer in the spin/dry phases.
            timer_enable <= ~(pausable_c & lid_open);
        end
    end

endmodule
